// File: rtl/mem_arb_pkg.sv
// Shared types for mem_arbiter: FSM states, request payload, grant encoding.
package mem_arb_pkg;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;

    // Grant index doubles as the per-master index into packed request arrays.
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} arb_state_e;

    typedef struct packed {
        logic                  instr;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_STRB_W-1:0] wstrb;
    } mem_req_t;

    function automatic arb_state_e wait_state(input logic gnt);
        return (gnt == GNT_D) ? WAIT_D : WAIT_I;
    endfunction
endpackage

// File: rtl/mem_arb_req_buf.sv
// One-entry capture buffer holding a request that could not be issued yet.
module mem_arb_req_buf
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     clear,
    input  mem_req_t req,
    output logic     full,
    output mem_req_t buf_req
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 1'b0;
            buf_req <= '0;
        end else if (load) begin
            full    <= 1'b1;
            buf_req <= req;
        end else if (clear) begin
            full    <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one valid/ready memory slave between the instruction and data masters.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_valid,
    input  logic              imem_instr,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_wdata,
    input  logic [DATA_W/8-1:0] imem_wstrb,
    output logic [DATA_W-1:0] imem_rdata,
    output logic              imem_ready,
    input  logic              dmem_valid,
    input  logic              dmem_instr,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W/8-1:0] dmem_wstrb,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_ready,
    output logic              mem_valid,
    output logic              mem_instr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              arb_error
);
    // Request payload is a package struct, so widths are fixed there.
    if (ADDR_W != ARB_ADDR_W || DATA_W != ARB_DATA_W) begin : g_bad_width
        $error("mem_arbiter: ADDR_W/DATA_W must match mem_arb_pkg");
    end

    arb_state_e     state;
    mem_req_t [1:0] live_req, buf_req, cand_req;
    logic     [1:0] live_vld, live_ok, buf_full, buf_load, buf_clr, cand, viol_full;
    logic           win, issue, in_wait, owner, viol_owner;

    assign live_vld[GNT_I] = imem_valid;
    assign live_vld[GNT_D] = dmem_valid;
    assign live_req[GNT_I] = {imem_instr, imem_addr, imem_wdata, imem_wstrb};
    assign live_req[GNT_D] = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb};

    assign in_wait    = (state != IDLE);
    assign owner      = (state == WAIT_D) ? GNT_D : GNT_I;
    assign viol_owner = in_wait & live_vld[owner];
    assign issue      = ~in_wait & (|cand);

    for (genvar m = 0; m < 2; m++) begin : g_mst
        localparam logic ID = 1'(m);
        // A live strobe is only accepted when it has somewhere to go.
        assign viol_full[m] = live_vld[m] & buf_full[m];
        assign live_ok[m]   = live_vld[m] & ~buf_full[m] & ~(in_wait & (owner == ID));
        assign cand[m]      = buf_full[m] | live_vld[m];
        assign cand_req[m]  = buf_full[m] ? buf_req[m] : live_req[m];
        assign buf_clr[m]   = issue & (win == ID) & buf_full[m];
        assign buf_load[m]  = live_ok[m] & ~(issue & (win == ID));

        mem_arb_req_buf u_buf (
            .clk     (clk),
            .rst     (rst),
            .load    (buf_load[m]),
            .clear   (buf_clr[m]),
            .req     (live_req[m]),
            .full    (buf_full[m]),
            .buf_req (buf_req[m])
        );
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_comb begin
        if (cand[GNT_I] & cand[GNT_D]) win = ~last_grant;
        else                           win = cand[GNT_D] ? GNT_D : GNT_I;
    end
`else
    always_comb begin
        win = cand[GNT_D] ? GNT_D : GNT_I;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            arb_error  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= GNT_I;
`endif
        end else begin
            if ((|viol_full) | viol_owner) arb_error <= 1'b1;
            case (state)
                IDLE: if (issue) begin
                    state <= wait_state(win);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant <= win;
`endif
                end
                WAIT_I, WAIT_D: if (mem_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency issue path: the slave sees the winner in the request cycle.
    assign mem_valid = issue;
    assign {mem_instr, mem_addr, mem_wdata, mem_wstrb} = cand_req[win];

    assign imem_ready = (state == WAIT_I) & mem_ready;
    assign dmem_ready = (state == WAIT_D) & mem_ready;
    assign imem_rdata = imem_ready ? mem_rdata : '0;
    assign dmem_rdata = dmem_ready ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a queue-based transaction model.
module tb_mem_arbiter;
    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_valid, imem_instr, imem_ready;
    logic [31:0] imem_addr, imem_wdata, imem_rdata;
    logic [3:0]  imem_wstrb;
    logic        dmem_valid, dmem_instr, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        mem_valid, mem_instr, mem_ready, arb_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .arb_error(arb_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: per-master queue of waiting requests (depth 1), current owner, sticky error.
    req_t pq[2][$];
    int   owner = -1;
    bit   err   = 1'b0;
    bit   last  = 1'b0;
    // Slave: responds slv_lat cycles after an issue.
    bit   slv_busy = 1'b0;
    int   slv_cnt  = 0;
    int   slv_lat  = 2;
    bit   fix_data = 1'b0;
    logic [31:0] fix_val = '0;
    // Observations of the DUT for directed checks.
    req_t ri, rd, last_iss;
    int   i_rdy_n, d_rdy_n;
    logic [31:0] i_last_rd, d_last_rd;
    bit   iss_log[$];

    function automatic bit busy(input int m);
        return owner == m || pq[m].size() != 0;
    endfunction

    function automatic req_t rnd_req(input bit d);
        req_t r;
        r.instr = d ? 1'b0 : 1'($urandom_range(0, 1));
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.wstrb = 4'($urandom);
        return r;
    endfunction

    function automatic req_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        req_t r;
        r.instr = 1'b0; r.addr = a; r.wdata = wd; r.wstrb = ws;
        return r;
    endfunction

    task automatic clr_obs();
        i_rdy_n = 0; d_rdy_n = 0; i_last_rd = '0; d_last_rd = '0;
        last_iss = '0; iss_log.delete();
    endtask

    task automatic step(input bit iv, input bit dv, input bit spur);
        bit lv[2]; req_t lr[2]; bit has[2]; bit e_rdy[2]; logic [31:0] e_rd[2];
        bit mr, e_mv, err_n; req_t e_req; logic [31:0] mrd; int w, own_n;
        @(negedge clk);
        mr  = (slv_busy && slv_cnt == 0) || spur;
        mrd = fix_data ? fix_val : $urandom;
        imem_valid = iv; {imem_instr, imem_addr, imem_wdata, imem_wstrb} = ri;
        dmem_valid = dv; {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb} = rd;
        mem_ready = mr; mem_rdata = mrd;
        #1;
        lv = '{iv, dv}; lr = '{ri, rd};
        e_mv = 0; e_req = '0; e_rdy = '{0, 0}; e_rd = '{0, 0}; err_n = 0; own_n = owner;
        if (owner < 0) begin
            for (int m = 0; m < 2; m++)
                if (lv[m] && pq[m].size() != 0) begin err_n = 1; lv[m] = 0; end
            for (int m = 0; m < 2; m++) has[m] = lv[m] || pq[m].size() != 0;
            if (has[0] || has[1]) begin
                if (has[0] && has[1]) w = RR_EN ? int'(!last) : 1;
                else                  w = has[1] ? 1 : 0;
                e_mv  = 1;
                e_req = (pq[w].size() != 0) ? pq[w].pop_front() : lr[w];
                if (lv[1-w]) pq[1-w].push_back(lr[1-w]);
                own_n = w;
                last  = w[0];
            end
        end else begin
            if (lv[owner]) err_n = 1;
            if (lv[1-owner]) begin
                if (pq[1-owner].size() != 0) err_n = 1;
                else pq[1-owner].push_back(lr[1-owner]);
            end
            if (mr) begin
                e_rdy[owner] = 1; e_rd[owner] = mrd; own_n = -1;
            end
        end
        check("mem_valid", mem_valid, e_mv);
        if (e_mv) check("mem_req", {mem_instr, mem_addr, mem_wdata, mem_wstrb}, e_req);
        check("imem_ready", imem_ready, e_rdy[0]);
        check("imem_rdata", imem_rdata, e_rd[0]);
        check("dmem_ready", dmem_ready, e_rdy[1]);
        check("dmem_rdata", dmem_rdata, e_rd[1]);
        check("arb_error", arb_error, err);
        if (mem_valid) begin
            last_iss = {mem_instr, mem_addr, mem_wdata, mem_wstrb};
            iss_log.push_back(mem_addr >= 32'h200);
        end
        if (imem_ready) begin i_rdy_n++; i_last_rd = imem_rdata; end
        if (dmem_ready) begin d_rdy_n++; d_last_rd = dmem_rdata; end
        err   = err | err_n;
        owner = own_n;
        if (slv_busy && slv_cnt == 0) slv_busy = 0;
        else if (slv_busy) slv_cnt--;
        if (e_mv) begin slv_busy = 1; slv_cnt = slv_lat - 1; end
    endtask

    task automatic drain();
        int n = 0;
        while ((owner >= 0 || pq[0].size() != 0 || pq[1].size() != 0) && n < 40) begin
            step(0, 0, 0); n++;
        end
        if (owner >= 0 || pq[0].size() != 0 || pq[1].size() != 0)
            check("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; imem_valid = 0; dmem_valid = 0; mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
        owner = -1; pq[0].delete(); pq[1].delete(); err = 0; last = 0; slv_busy = 0;
        #1;
        check("rst_mem_valid", mem_valid, 0);
        check("rst_imem_ready", imem_ready, 0);
        check("rst_dmem_ready", dmem_ready, 0);
        check("rst_imem_rdata", imem_rdata, 0);
        check("rst_dmem_rdata", dmem_rdata, 0);
        check("rst_arb_error", arb_error, 0);
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        bit exp_ord[8];
        int il, dl, n;
        imem_valid = 0; imem_instr = 0; imem_addr = '0; imem_wdata = '0; imem_wstrb = '0;
        dmem_valid = 0; dmem_instr = 0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        mem_ready = 0; mem_rdata = '0;
        ri = '0; rd = '0;
        clr_obs();
        do_reset();

        // Single read with 2-cycle slave.
        slv_lat = 2; fix_data = 1; fix_val = 32'hDEADBEEF;
        rd = mk(32'h100, 32'h0, 4'h0);
        step(0, 1, 0);
        repeat (5) step(0, 0, 0);
        check("t1_drdy_cnt", d_rdy_n, 1);
        check("t1_irdy_cnt", i_rdy_n, 0);
        check("t1_rdata", d_last_rd, 32'hDEADBEEF);
        fix_data = 0;

        // Simultaneous requests: data first, instr buffered.
        clr_obs();
        ri = mk(32'h0, 32'h0, 4'h0); ri.instr = 1'b1;
        rd = mk(32'h200, 32'h0, 4'h0);
        step(1, 1, 0);
        repeat (8) step(0, 0, 0);
        check("t2_n_iss", iss_log.size(), 2);
        check("t2_first", iss_log.size() > 0 ? iss_log[0] : 1'bx, 1'b1);
        check("t2_second", iss_log.size() > 1 ? iss_log[1] : 1'bx, 1'b0);
        check("t2_rdy_cnt", {i_rdy_n[7:0], d_rdy_n[7:0]}, 16'h0101);

        // Data request lands on the same cycle as the instr response.
        clr_obs();
        slv_lat = 3;
        ri = mk(32'h40, 32'h0, 4'h0);
        step(1, 0, 0);
        n = 0;
        while (!(slv_busy && slv_cnt == 0) && n < 10) begin step(0, 0, 0); n++; end
        rd = mk(32'h300, 32'h12345678, 4'hF);
        step(0, 1, 0);
        step(0, 0, 0);
        check("t3_req", last_iss, mk(32'h300, 32'h12345678, 4'hF));
        drain();

        // Contention order over four back-to-back requests per master.
        clr_obs();
        slv_lat = 1; il = 0; dl = 0; n = 0;
        while ((il < 4 || dl < 4 || busy(0) || busy(1)) && n < 200) begin
            bit iv, dv;
            iv = il < 4 && !busy(0);
            dv = dl < 4 && !busy(1);
            ri = mk(32'(il * 4), 32'h0, 4'h0);
            rd = mk(32'h200 + 32'(dl * 4), 32'h0, 4'h0);
            step(iv, dv, 0);
            if (iv) il++;
            if (dv) dl++;
            n++;
        end
        if (RR_EN) exp_ord = '{1, 0, 1, 0, 1, 0, 1, 0};
        else       exp_ord = '{1, 1, 1, 1, 0, 0, 0, 0};
        check("t4_n_iss", iss_log.size(), 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("t4_order%0d", k), iss_log.size() > k ? iss_log[k] : 1'bx, exp_ord[k]);

        // Second data strobe while data is already buffered.
        do_reset();
        clr_obs();
        slv_lat = 3;
        ri = mk(32'h10, 32'h0, 4'h0);
        step(1, 0, 0);
        rd = mk(32'h210, 32'h55, 4'h3);
        step(0, 1, 0);
        rd = mk(32'h220, 32'h66, 4'hC);
        step(0, 1, 0);
        drain();
        step(0, 0, 0);
        check("t5_err", arb_error, 1);
        check("t5_drdy_cnt", d_rdy_n, 1);
        check("t5_served", last_iss, mk(32'h210, 32'h55, 4'h3));

        // Reset while waiting on the data response, then a stale ready.
        do_reset();
        slv_lat = 4;
        rd = mk(32'h200, 32'h0, 4'h0);
        step(0, 1, 0);
        step(0, 0, 0);
        do_reset();
        clr_obs();
        step(0, 0, 1);
        check("t6_no_rdy", {i_rdy_n[7:0], d_rdy_n[7:0]}, 16'h0);
        slv_lat = 2;
        rd = mk(32'h240, 32'h0, 4'h0);
        step(0, 1, 0);
        check("t6_reissue", last_iss, mk(32'h240, 32'h0, 4'h0));
        drain();

        // Random legal traffic with random latency and stray slave readies.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bit iv, dv, sp;
            slv_lat = $urandom_range(1, 4);
            iv = !busy(0) && $urandom_range(0, 2) == 0;
            dv = !busy(1) && $urandom_range(0, 2) == 0;
            sp = !slv_busy && $urandom_range(0, 7) == 0;
            ri = rnd_req(0);
            rd = rnd_req(1);
            step(iv, dv, sp);
        end
        drain();
        check("rand_err", arb_error, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
